// File: rtl/riscv_io_pkg.sv
// Shared IO map constants and UART transmitter state type for the data-memory bridge.
package riscv_io_pkg;

  localparam int IO_SELECT_BIT = 22;

  localparam logic [2:0] IO_LEDS        = 3'd0;
  localparam logic [2:0] IO_UART_DATA   = 3'd1;
  localparam logic [2:0] IO_UART_STATUS = 3'd2;
  localparam logic [2:0] IO_CYCLE       = 3'd3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx8n1.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit.
// start_i is honoured only in IDLE; the line is driven from a register.
module uart_tx8n1
  import riscv_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  output logic        tx_o,
  output logic        busy_o,
  output uart_state_e state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d anticipates the bit that the next state will present, so the line
  // changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (start_i) begin
          state_d = UART_START;
          shift_d = data_i;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      UART_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = UART_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = UART_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_o    = tx_q;
  assign busy_o  = (state_q != UART_IDLE);
  assign state_o = state_q;

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-memory stage bridge: word RAM below the IO select bit, LED / UART / cycle
// counter registers above it. Loads are combinational, stores take effect at the edge.
module dmem_io_bridge
  import riscv_io_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0]      mem [RAM_WORDS];
  logic             io_sel;
  logic [2:0]       io_off;
  logic [IDX_W-1:0] ram_idx;
  logic             wr_ram, wr_leds, wr_uart, wr_status, wr_cycle;
  logic [7:0]       leds_q, leds_d;
  logic [31:0]      cycle_q, cycle_d;
  logic             overrun_q, overrun_d;
  logic             uart_busy;
  uart_state_e      uart_state;
  logic             unused_addr;

  // Only a few address bits are decoded; the rest alias by design.
  assign unused_addr = ^Address;

  assign io_sel    = Address[IO_SELECT_BIT];
  assign io_off    = Address[4:2];
  assign ram_idx   = Address[IDX_W+1:2];
  assign wr_ram    = MemWrite & ~io_sel;
  assign wr_leds   = MemWrite & io_sel & (io_off == IO_LEDS);
  assign wr_uart   = MemWrite & io_sel & (io_off == IO_UART_DATA);
  assign wr_status = MemWrite & io_sel & (io_off == IO_UART_STATUS);
  assign wr_cycle  = MemWrite & io_sel & (io_off == IO_CYCLE);

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // Setting overrun takes priority over a status-register clear.
  always_comb begin
    leds_d    = wr_leds ? WriteData[7:0] : leds_q;
    cycle_d   = wr_cycle ? 32'd0 : cycle_q + 32'd1;
    overrun_d = overrun_q;
    if (wr_status) overrun_d = 1'b0;
    if (wr_uart && uart_busy) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q    <= '0;
      cycle_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      leds_q    <= leds_d;
      cycle_q   <= cycle_d;
      overrun_q <= overrun_d;
    end
  end

  uart_tx8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(wr_uart),
    .data_i (WriteData[7:0]),
    .tx_o   (uart_tx),
    .busy_o (uart_busy),
    .state_o(uart_state)
  );

  always_comb begin
    ReadData = '0;
    if (!io_sel) begin
      ReadData = mem[ram_idx];
    end else begin
      case (io_off)
        IO_LEDS:        ReadData = {24'd0, leds_q};
        IO_UART_STATUS: ReadData = {30'd0, overrun_q, (uart_state != UART_IDLE)};
        IO_CYCLE:       ReadData = cycle_q;
        default:        ReadData = '0;
      endcase
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Bench for dmem_io_bridge: directed scenarios plus random load/store traffic
// compared against a cycle-level behavioural model of the memory map and serial line.
module tb_dmem_io_bridge;

  localparam int RAM_WORDS = 1024;
  localparam int CPB       = 4;

  localparam logic [31:0] A_LEDS   = 32'h0040_0000;
  localparam logic [31:0] A_UART   = 32'h0040_0004;
  localparam logic [31:0] A_STATUS = 32'h0040_0008;
  localparam logic [31:0] A_CYCLE  = 32'h0040_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic        uart_tx;

  always #5 clk = ~clk;

  dmem_io_bridge #(
    .RAM_WORDS   (RAM_WORDS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .ReadData (ReadData),
    .leds     (leds),
    .uart_tx  (uart_tx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model state, as seen in the cycle after the most recent edge.
  logic [31:0] mem_m [RAM_WORDS];
  bit          written_m [RAM_WORDS];
  logic [7:0]  leds_m;
  logic [31:0] cycle_m;
  bit          overrun_m;
  int          busy_left;
  logic [0:0]  exp_q[$];
  logic        exp_tx_m;

  function automatic void model_reset();
    leds_m    = 8'd0;
    cycle_m   = 32'd0;
    overrun_m = 1'b0;
    busy_left = 0;
    exp_q.delete();
    exp_tx_m  = 1'b1;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % RAM_WORDS);
  endfunction

  function automatic int io_offset(input logic [31:0] a);
    return int'((a >> 2) & 32'd7);
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'd0;
    if (!a[22]) begin
      v = mem_m[ram_index(a)];
      return written_m[ram_index(a)];
    end
    case (io_offset(a))
      0: v = {24'd0, leds_m};
      2: v = {30'd0, overrun_m, (busy_left > 0)};
      3: v = cycle_m;
      default: v = 32'd0;
    endcase
    return 1'b1;
  endfunction

  function automatic void push_frame(input logic [7:0] d);
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < CPB; i++) exp_q.push_back(d[b]);
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
  endfunction

  function automatic void model_edge(input logic [31:0] a, input logic [31:0] d, input logic we);
    bit busy_pre = (busy_left > 0);
    bit accepted = 1'b0;
    bit cyc_wr   = we && a[22] && io_offset(a) == 3;
    if (we && !a[22]) begin
      mem_m[ram_index(a)]     = d;
      written_m[ram_index(a)] = 1'b1;
    end
    if (we && a[22]) begin
      case (io_offset(a))
        0: leds_m = d[7:0];
        1: begin
          if (busy_pre) overrun_m = 1'b1;
          else accepted = 1'b1;
        end
        2: overrun_m = 1'b0;
        default: ;
      endcase
    end
    cycle_m = cyc_wr ? 32'd0 : cycle_m + 32'd1;
    if (busy_left > 0) busy_left--;
    if (accepted) begin
      push_frame(d[7:0]);
      busy_left = 10 * CPB;
    end
    exp_tx_m = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
  endfunction

  // One bus cycle: drive after a falling edge, check the load, clock it, check registers.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we);
    logic [31:0] exp_rd;
    bit known;
    Address   = a;
    WriteData = d;
    MemWrite  = we;
    #1;
    known = model_read(a, exp_rd);
    if (known) check_eq("rdata", ReadData, exp_rd);
    model_edge(a, d, we);
    @(posedge clk);
    @(negedge clk);
    check_eq("leds", {24'd0, leds}, {24'd0, leds_m});
    check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx_m});
  endtask

  task automatic check_reset_outputs();
    MemWrite = 1'b0;
    Address  = A_STATUS;
    #1;
    check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("rst_leds", {24'd0, leds}, 32'd0);
    check_eq("rst_status", ReadData, 32'd0);
    Address = A_CYCLE;
    #1;
    check_eq("rst_cycle", ReadData, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c1, c2, a, d;
    int r, off;

    reset     = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    MemWrite  = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) written_m[i] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // RAM store and aliased load.
    step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step(32'h0000_0010, 32'd0, 1'b0);
    step(32'h0000_1010, 32'd0, 1'b0);
    check_eq("ram_alias", ReadData, 32'hDEAD_BEEF);

    // LED register.
    step(A_LEDS, 32'h0000_01A5, 1'b1);
    step(A_LEDS, 32'd0, 1'b0);
    check_eq("leds_a5", {24'd0, leds}, 32'h0000_00A5);

    // Frame of 0x55, overrun on a second store, clear via status write.
    step(A_UART, 32'h0000_0055, 1'b1);
    repeat (9) step(A_STATUS, 32'd0, 1'b0);
    step(A_UART, 32'h0000_0033, 1'b1);
    step(A_STATUS, 32'd0, 1'b0);
    step(A_STATUS, 32'd0, 1'b1);
    step(A_STATUS, 32'd0, 1'b0);
    repeat (30) step(A_STATUS, 32'd0, 1'b0);
    check_eq("frame_done_q", exp_q.size(), 32'd0);

    // Cycle counter spacing and clear.
    Address  = A_CYCLE;
    MemWrite = 1'b0;
    #1;
    c1 = ReadData;
    repeat (7) step(A_CYCLE, 32'd0, 1'b0);
    #1;
    c2 = ReadData;
    check_eq("cycle_diff", c2 - c1, 32'd7);
    step(A_CYCLE, 32'hFFFF_FFFF, 1'b1);
    step(A_CYCLE, 32'd0, 1'b0);
    step(A_CYCLE, 32'd0, 1'b0);

    // Reset during data bit 3 aborts the frame; a fresh frame follows.
    step(A_LEDS, 32'h0000_003C, 1'b1);
    step(A_UART, 32'h0000_00C3, 1'b1);
    repeat (17) step(A_STATUS, 32'd0, 1'b0);
    reset = 1'b0;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step(A_UART, 32'h0000_000F, 1'b1);
    repeat (45) step(A_STATUS, 32'd0, 1'b0);

    // Random traffic with aliased upper address bits.
    repeat (500) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        a = ($urandom() & ~32'h0040_0FFF) | (32'($urandom_range(0, 15)) << 2)
            | 32'($urandom_range(0, 3));
        d = $urandom();
        step(a, d, (r < 3));
      end else begin
        off = $urandom_range(0, 7);
        a = (($urandom() | 32'h0040_0000) & ~32'h0000_001C) | (32'(off) << 2);
        d = $urandom();
        step(a, d, 1'($urandom_range(0, 2) == 0));
      end
    end

    MemWrite = 1'b0;
    repeat (50) step(A_STATUS, 32'd0, 1'b0);
    check_eq("drain_q", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_io_bridge.md
DMEM_IO_BRIDGE -- requirements
Module: dmem_io_bridge

Interface
REQ-001 Parameter RAM_WORDS, default 1024, sets data RAM depth in 32-bit words (power of two).
REQ-002 Parameter CLKS_PER_BIT, default 4, sets UART clock cycles per bit (>=2).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Address  input  32  byte address from the core memory stage.
REQ-006 WriteData  input  32  store data, full word.
REQ-007 MemWrite  input  1  store strobe, sampled at the rising edge.
REQ-008 ReadData  output  32  load data, combinational from Address.
REQ-009 leds  output  8  LED register contents.
REQ-010 uart_tx  output  1  serial 8N1 line, idle high.

Function
REQ-011 Address[22]=0 SHALL select RAM; Address[22]=1 SHALL select IO space; Address[1:0] SHALL be ignored.
REQ-012 RAM index SHALL be Address[log2(RAM_WORDS)+1:2]; higher address bits alias (wrap-around).
REQ-013 RAM read SHALL be asynchronous: ReadData valid in the same cycle as Address, zero-latency.
REQ-014 RAM write SHALL occur at the rising edge when MemWrite=1 and Address[22]=0; a same-cycle read returns old data.
REQ-015 IO map by Address[4:2]: 0 LEDS (RW, bits 7:0), 1 UART_DATA (W), 2 UART_STATUS (R: bit0 busy, bit1 overrun; W: any write clears overrun), 3 CYCLE (R; W clears).
REQ-016 Unmapped IO offsets (4-7) SHALL read 0 and ignore writes; unused read bits SHALL be 0.
REQ-017 CYCLE SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF->0; a write SHALL load 0 and win over that cycle's increment.
REQ-018 UART FSM states: IDLE, START, DATA, STOP; busy = state != IDLE.
REQ-019 Write to UART_DATA in IDLE SHALL latch WriteData[7:0] and enter START at that edge.
REQ-020 Write to UART_DATA when busy SHALL be dropped and set overrun; an overrun set and clear on the same edge SHALL leave overrun set.
REQ-021 uart_tx SHALL be 0 for CLKS_PER_BIT cycles in START, then data bits LSB first for CLKS_PER_BIT cycles each, then 1 for CLKS_PER_BIT cycles in STOP, then IDLE.
REQ-022 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles of busy; a write on the last STOP cycle SHALL still be dropped.
REQ-023 uart_tx SHALL be driven from a register (glitch-free), 1 in IDLE.

Reset
REQ-024 On reset low: leds=0, uart_tx=1, FSM=IDLE, bit and baud counters=0, overrun=0, CYCLE=0, all asynchronously.
REQ-025 Reset mid-frame SHALL abort the frame immediately with uart_tx=1; no partial resume after release.
REQ-026 RAM contents SHALL NOT be reset.

Structure
REQ-027 Package riscv_io_pkg SHALL hold IO offsets (IO_LEDS, IO_UART_DATA, IO_UART_STATUS, IO_CYCLE), IO_SELECT_BIT=22 and the UART state enum.
REQ-028 The UART transmitter SHALL be one sub-module, uart_tx8n1 (inputs: start, data[7:0]; outputs: tx, busy).
REQ-029 Address decode, RAM, LED/CYCLE/overrun registers and ReadData mux SHALL remain in dmem_io_bridge.

Verification
REQ-030 Store 0xDEADBEEF to 0x00000010, then load 0x00000010 and 0x00001010 (RAM_WORDS=1024) -> both return 0xDEADBEEF.
REQ-031 Store 0x000001A5 to 0x00400000 -> leds=0xA5 the next cycle; load 0x00400000 returns 0x000000A5.
REQ-032 Store 0x55 to 0x00400004 with CLKS_PER_BIT=4 -> uart_tx 0 for 4 cycles, bits 1,0,1,0,1,0,1,0 for 4 cycles each, 1 for 4 cycles; status bit0=1 for 40 cycles.
REQ-033 Second store 0x33 to UART_DATA 10 cycles into frame -> line still carries 0x55, status reads 0x3; store to 0x00400008 -> status reads 0x1.
REQ-034 Read CYCLE at two instants 7 cycles apart -> difference 7; store to 0x0040000C -> next read returns 1 cycle later's count from 0.
REQ-035 Assert reset low during DATA bit 3 -> uart_tx=1, leds=0, status=0 immediately; after release, store 0x0F -> full correct frame.
